// File: rtl/mycpu_pkg.sv
// mycpu_pkg -- shared types and constants for the mycpu control units.
//   opcode_t    : 7-bit opcode map. Register ops are 7'b000_ffff, where ffff
//                 is the function select passed straight to the function unit.
//   cu_state_t  : multi-cycle control unit states.
//   op_class_t  : decoder classification used by the FSM for sequencing.
//   ctrl_word_t : one cycle's control word (rs, halted, illegal are added
//                 by the top level).
package mycpu_pkg;

  localparam int OPC_W = 7;

  typedef enum logic [OPC_W-1:0] {
    OP_MOVA = 7'h00, OP_INC  = 7'h01, OP_ADD  = 7'h02, OP_MUL  = 7'h03,
    OP_SRA  = 7'h04, OP_SUB  = 7'h05, OP_DEC  = 7'h06, OP_SLA  = 7'h07,
    OP_AND  = 7'h08, OP_OR   = 7'h09, OP_XOR  = 7'h0A, OP_NOT  = 7'h0B,
    OP_MOVB = 7'h0C, OP_SHR  = 7'h0D, OP_SHL  = 7'h0E, OP_CLR  = 7'h0F,
    OP_LD   = 7'h10, OP_ST   = 7'h11, OP_LDI  = 7'h12, OP_ADI  = 7'h13,
    OP_BRZ  = 7'h20, OP_BRN  = 7'h21, OP_JMP  = 7'h22,
    OP_IOR  = 7'h30, OP_IOW  = 7'h31,
    OP_SHLN = 7'h40, OP_SHRN = 7'h41,
    OP_HAL  = 7'h7F
  } opcode_t;

  typedef enum logic [2:0] {
    ST_RST, ST_INF, ST_EX0, ST_XL, ST_HLT, ST_ILL
  } cu_state_t;

  typedef enum logic [2:0] {
    CL_REG, CL_MEM, CL_SHN, CL_HAL, CL_MISC, CL_UNDEF
  } op_class_t;

  localparam logic [3:0] FS_MOVA = 4'b0000;
  localparam logic [3:0] FS_ADD  = 4'b0010;
  localparam logic [3:0] FS_MOVB = 4'b1100;
  localparam logic [3:0] FS_SHR  = 4'b1101;
  localparam logic [3:0] FS_SHL  = 4'b1110;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [1:0] MD_FU   = 2'b00;
  localparam logic [1:0] MD_MEM  = 2'b01;

  typedef struct packed {
    logic       il;
    logic [1:0] ps;
    logic       rw;
    logic       mm;
    logic [1:0] md;
    logic       mb;
    logic [3:0] fs;
    logic       wen;
    logic       iom;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '{il: 1'b0, ps: PS_HOLD, rw: 1'b0, mm: 1'b0,
                                     md: MD_FU, mb: 1'b0, fs: 4'h0, wen: 1'b1,
                                     iom: 1'b0};

endpackage

// File: rtl/cu_mc_dec.sv
// cu_mc_dec -- combinational opcode decoder for cu_mc.
// Produces the single-cycle execute control word assuming memory is ready,
// plus a class the FSM uses for stalls, shift loops, halt and undefined ops.
// Ports:
//   opc : opcode field of the instruction register
//   z   : zero flag
//   n   : negative flag
//   cw  : execute-cycle control word
//   cls : opcode class
module cu_mc_dec
  import mycpu_pkg::*;
(
  input  logic [OPC_W-1:0] opc,
  input  logic             z,
  input  logic             n,
  output ctrl_word_t       cw,
  output op_class_t        cls
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cw  = CW_IDLE;
    cls = CL_MISC;
    case (opc)
      OP_LD:   begin cls = CL_MEM; cw.md = MD_MEM; cw.rw = 1'b1; cw.ps = PS_INC; end
      OP_ST:   begin cls = CL_MEM; cw.wen = 1'b0; cw.ps = PS_INC; end
      OP_LDI:  begin cls = CL_REG; cw.rw = 1'b1; cw.mb = 1'b1; cw.fs = FS_MOVB; cw.ps = PS_INC; end
      OP_ADI:  begin cls = CL_REG; cw.rw = 1'b1; cw.mb = 1'b1; cw.fs = FS_ADD;  cw.ps = PS_INC; end
      OP_BRZ:  cw.ps = z ? PS_BR : PS_INC;
      OP_BRN:  cw.ps = n ? PS_BR : PS_INC;
      OP_JMP:  cw.ps = PS_JMP;
      OP_IOR:  begin cw.iom = 1'b1; cw.rw = 1'b1; cw.md = MD_MEM; cw.ps = PS_INC; end
      OP_IOW:  begin cw.iom = 1'b1; cw.wen = 1'b0; cw.ps = PS_INC; end
      OP_SHLN: begin cls = CL_SHN; cw.rw = 1'b1; cw.fs = FS_SHL; cw.ps = PS_INC; end
      OP_SHRN: begin cls = CL_SHN; cw.rw = 1'b1; cw.fs = FS_SHR; cw.ps = PS_INC; end
      OP_HAL:  begin cls = CL_HAL; cw.ps = PS_INC; end
      default: begin
        if (opc[6:4] == 3'b000) begin
          // Register op: the low nibble is the function select itself.
          cls   = CL_REG;
          cw.rw = 1'b1;
          cw.fs = opc[3:0];
          cw.ps = PS_INC;
        end else begin
          cls   = CL_UNDEF;
          cw.ps = PS_INC;
        end
      end
    endcase
  end

endmodule

// File: rtl/cu_mc.sv
// cu_mc -- parametrised multi-cycle control unit for the mycpu datapath.
// Sequences fetch (INF), execute (EX0), the N-step shift loop (XL), halt (HLT)
// and, when CU_ILLEGAL_TRAP_EN is defined, the illegal-opcode trap (ILL).
// Without CU_ILLEGAL_TRAP_EN an undefined opcode executes as a NOP.
// Outputs are decoded from the state register and the live inputs, since the
// instruction load and memory stalls must follow mem_rdy_in in the same cycle.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   ins_in           : instruction {opcode[6:0], DA, AA, BA}
//   z_in, n_in       : zero / negative flags
//   mem_rdy_in       : memory fetch/data valid
//   resume_in        : leave HLT
//   il_out, ps_out   : IR load, PC op (00 hold, 01 inc, 10 branch, 11 jump)
//   rw_out, rs_out   : register write, {DA,AA,BA} selects (MSB = temp bank)
//   mm_out, md_out   : address mux (1 = PC), write-data mux (00 FU, 01 mem)
//   mb_out, fs_out   : B mux (1 = immediate), function select
//   wen_out, iom_out : memory/IO write enable (active-low), IO space select
//   halted_out       : in HLT
//   illegal_out      : in ILL
module cu_mc
  import mycpu_pkg::*;
#(
  parameter  int REG_AW = 3,
  parameter  int FS_W   = 4,
  localparam int INS_W  = 7 + 3*REG_AW,
  localparam int RS_W   = REG_AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INS_W-1:0]  ins_in,
  input  logic              z_in,
  input  logic              n_in,
  input  logic              mem_rdy_in,
  input  logic              resume_in,
  output logic              il_out,
  output logic [1:0]        ps_out,
  output logic              rw_out,
  output logic [3*RS_W-1:0] rs_out,
  output logic              mm_out,
  output logic [1:0]        md_out,
  output logic              mb_out,
  output logic [FS_W-1:0]   fs_out,
  output logic              wen_out,
  output logic              iom_out,
  output logic              halted_out,
  output logic              illegal_out
);

  cu_state_t         state_q;
  logic [REG_AW-1:0] cnt_r;

  logic [OPC_W-1:0]  opc;
  logic [REG_AW-1:0] da, aa, ba;
  ctrl_word_t        dec_cw, cw;
  op_class_t         cls;
  logic [3*RS_W-1:0] rs_fields, rs_loop, rs;

  assign opc = ins_in[INS_W-1 -: OPC_W];
  assign da  = ins_in[3*REG_AW-1 -: REG_AW];
  assign aa  = ins_in[2*REG_AW-1 -: REG_AW];
  assign ba  = ins_in[REG_AW-1:0];

  assign rs_fields = {1'b0, da, 1'b0, aa, 1'b0, ba};
  // Loop steps shift DA in place.
  assign rs_loop   = {1'b0, da, 1'b0, da, {RS_W{1'b0}}};

  cu_mc_dec u_dec (
    .opc (opc),
    .z   (z_in),
    .n   (n_in),
    .cw  (dec_cw),
    .cls (cls)
  );

  // Control word for the current cycle, with stall and loop overrides.
  always_comb begin
    cw = CW_IDLE;
    rs = '0;
    case (state_q)
      ST_INF: begin
        cw.mm = 1'b1;
        cw.il = mem_rdy_in;
      end
      ST_EX0: begin
        cw = dec_cw;
        rs = (cls == CL_UNDEF) ? '0 : rs_fields;
        case (cls)
          CL_MEM: begin
            if (!mem_rdy_in) begin
              cw.ps  = PS_HOLD;
              cw.rw  = 1'b0;
              cw.wen = 1'b1;
            end
          end
          CL_SHN: begin
            if (ba == '0)                cw.fs = FS_MOVA;
            else if (ba != REG_AW'(1))   cw.ps = PS_HOLD;
          end
          CL_UNDEF: begin
`ifdef CU_ILLEGAL_TRAP_EN
            cw.ps = PS_HOLD;
`else
            cw.ps = PS_INC;
`endif
          end
          default: ;
        endcase
      end
      ST_XL: begin
        cw.rw = 1'b1;
        cw.fs = dec_cw.fs;
        cw.ps = (cnt_r == REG_AW'(1)) ? PS_INC : PS_HOLD;
        rs    = rs_loop;
      end
      default: ;
    endcase
  end

  // NOTE: state_q and cnt_r use non-blocking assignments so every register
  // samples the pre-edge values; reset is asynchronous and clears both at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RST;
      cnt_r   <= '0;
    end else begin
      case (state_q)
        ST_RST: state_q <= ST_INF;
        ST_INF: if (mem_rdy_in) state_q <= ST_EX0;
        ST_EX0: begin
          case (cls)
            CL_MEM: if (mem_rdy_in) state_q <= ST_INF;
            CL_SHN: begin
              if (ba != '0) cnt_r <= ba - REG_AW'(1);
              state_q <= (ba > REG_AW'(1)) ? ST_XL : ST_INF;
            end
            CL_HAL: state_q <= ST_HLT;
`ifdef CU_ILLEGAL_TRAP_EN
            CL_UNDEF: state_q <= ST_ILL;
`endif
            default: state_q <= ST_INF;
          endcase
        end
        ST_XL: begin
          cnt_r <= cnt_r - REG_AW'(1);
          if (cnt_r == REG_AW'(1)) state_q <= ST_INF;
        end
        ST_HLT: if (resume_in) state_q <= ST_INF;
        ST_ILL: state_q <= ST_ILL;
        default: state_q <= ST_RST;
      endcase
    end
  end

  assign il_out     = cw.il;
  assign ps_out     = cw.ps;
  assign rw_out     = cw.rw;
  assign rs_out     = rs;
  assign mm_out     = cw.mm;
  assign md_out     = cw.md;
  assign mb_out     = cw.mb;
  assign fs_out     = FS_W'(cw.fs);
  assign wen_out    = cw.wen;
  assign iom_out    = cw.iom;
  assign halted_out = (state_q == ST_HLT);
`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal_out = (state_q == ST_ILL);
`else
  assign illegal_out = 1'b0;
`endif

endmodule

// File: tb/tb_cu_mc.sv
// tb_cu_mc -- self-checking bench for cu_mc (REG_AW=3, FS_W=4).
// Each instruction is expanded by a transaction-level model into its expected
// per-cycle control words (fetch stalls, execute stalls, BA-cycle shift loops).
// Fields a given instruction leaves unconstrained are masked with a care vector.
module tb_cu_mc;
  import mycpu_pkg::*;

  localparam int REG_AW = 3;
  localparam int FS_W   = 4;
  localparam int INS_W  = 7 + 3*REG_AW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [INS_W-1:0]  ins_in;
  logic              z_in, n_in, mem_rdy_in, resume_in;
  logic              il_out, rw_out, mm_out, mb_out, wen_out, iom_out;
  logic              halted_out, illegal_out;
  logic [1:0]        ps_out, md_out;
  logic [11:0]       rs_out;
  logic [FS_W-1:0]   fs_out;

  always #5 clk = ~clk;

  cu_mc #(.REG_AW(REG_AW), .FS_W(FS_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ins_in      (ins_in),
    .z_in        (z_in),
    .n_in        (n_in),
    .mem_rdy_in  (mem_rdy_in),
    .resume_in   (resume_in),
    .il_out      (il_out),
    .ps_out      (ps_out),
    .rw_out      (rw_out),
    .rs_out      (rs_out),
    .mm_out      (mm_out),
    .md_out      (md_out),
    .mb_out      (mb_out),
    .fs_out      (fs_out),
    .wen_out     (wen_out),
    .iom_out     (iom_out),
    .halted_out  (halted_out),
    .illegal_out (illegal_out)
  );

  typedef struct packed {
    logic        il;
    logic [1:0]  ps;
    logic        rw;
    logic [11:0] rs;
    logic        mm;
    logic [1:0]  md;
    logic        mb;
    logic [3:0]  fs;
    logic        wen;
    logic        iom;
    logic        hal;
    logic        ill;
  } ow_t;

  ow_t obs;
  assign obs = {il_out, ps_out, rw_out, rs_out, mm_out, md_out, mb_out, fs_out,
                wen_out, iom_out, halted_out, illegal_out};

  int vectors     = 0;
  int miscompares = 0;

  function automatic ow_t idle_w();
    ow_t w;
    w     = '0;
    w.wen = 1'b1;
    return w;
  endfunction

  function automatic ow_t all_care();
    ow_t w;
    w = '1;
    return w;
  endfunction

  task automatic check(input string tag, input ow_t e, input ow_t c);
    vectors++;
    assert ((obs & c) === (e & c)) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (care %h)", tag, obs, e, c);
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Inputs are driven at the falling edge and outputs checked 1 ns later.
  task automatic step(input string tag, input ow_t e, input ow_t c, input logic rdy);
    mem_rdy_in = rdy;
    #1;
    check(tag, e, c);
    @(negedge clk);
  endtask

  task automatic fetch(input int stalls);
    ow_t e;
    e    = idle_w();
    e.mm = 1'b1;
    for (int i = 0; i < stalls; i++) step("inf_stall", e, all_care(), 1'b0);
    e.il = 1'b1;
    step("inf_load", e, all_care(), 1'b1);
  endtask

  // Fetch then execute one instruction, checking every cycle.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] da,
                           input logic [2:0] aa, input logic [2:0] ba,
                           input logic z, input logic n,
                           input int fst, input int xst);
    ow_t         e, c;
    logic [11:0] rsf;
    logic        rnd;
    ins_in    = {opc, da, aa, ba};
    z_in      = z;
    n_in      = n;
    resume_in = 1'b0;
    fetch(fst);
    rsf  = {1'b0, da, 1'b0, aa, 1'b0, ba};
    e    = idle_w();
    c    = all_care();
    c.rs = '0;
    rnd  = 1'($urandom_range(1));
    if (opc[6:4] == 3'b000) begin
      e.rw = 1'b1; e.ps = 2'b01; e.fs = opc[3:0]; e.rs = rsf; c.rs = '1;
      step("ex_reg", e, c, rnd);
    end else begin
      case (opc)
        OP_LDI, OP_ADI: begin
          e.rw = 1'b1; e.mb = 1'b1; e.ps = 2'b01; e.rs = rsf; c.rs = '1;
          e.fs = (opc == OP_LDI) ? 4'b1100 : 4'b0010;
          step("ex_imm", e, c, rnd);
        end
        OP_LD: begin
          e.md = 2'b01;
          for (int i = 0; i < xst; i++) step("ld_stall", e, c, 1'b0);
          e.rw = 1'b1; e.ps = 2'b01;
          step("ld_done", e, c, 1'b1);
        end
        OP_ST: begin
          for (int i = 0; i < xst; i++) step("st_stall", e, c, 1'b0);
          e.wen = 1'b0; e.ps = 2'b01;
          step("st_done", e, c, 1'b1);
        end
        OP_BRZ: begin e.ps = z ? 2'b10 : 2'b01; step("brz", e, c, rnd); end
        OP_BRN: begin e.ps = n ? 2'b10 : 2'b01; step("brn", e, c, rnd); end
        OP_JMP: begin e.ps = 2'b11; step("jmp", e, c, rnd); end
        OP_IOR: begin
          e.iom = 1'b1; e.rw = 1'b1; e.md = 2'b01; e.ps = 2'b01;
          step("ior", e, c, rnd);
        end
        OP_IOW: begin
          e.iom = 1'b1; e.wen = 1'b0; e.ps = 2'b01;
          step("iow", e, c, rnd);
        end
        OP_SHLN, OP_SHRN: begin
          c = all_care();
          if (ba == 3'd0) begin
            e.rw = 1'b1; e.ps = 2'b01; e.fs = 4'b0000; e.rs = rsf;
            step("shn_ba0", e, c, rnd);
          end else begin
            // BA cycles of DA <= shift(src), PC advances only on the last.
            for (int k = 1; k <= int'(ba); k++) begin
              e    = idle_w();
              e.rw = 1'b1;
              e.fs = (opc == OP_SHLN) ? 4'b1110 : 4'b1101;
              e.ps = (k == int'(ba)) ? 2'b01 : 2'b00;
              e.rs = (k == 1) ? rsf : {1'b0, da, 1'b0, da, 4'b0000};
              step("shn_step", e, c, 1'($urandom_range(1)));
            end
          end
        end
        OP_HAL: begin
          e.ps = 2'b01;
          step("hal_ex", e, c, rnd);
          e     = idle_w();
          e.hal = 1'b1;
          for (int i = 0; i < 10; i++) step("halted", e, all_care(), 1'b1);
          resume_in = 1'b1;
          step("halt_resume", e, all_care(), 1'b1);
          resume_in = 1'b0;
        end
        default: begin
          e.ps = 2'b01;
          step("undef_nop", e, all_care(), rnd);
        end
      endcase
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [11];
    logic [6:0] op;
    ow_t        e;
    ops = '{OP_LD, OP_ST, OP_LDI, OP_ADI, OP_BRZ, OP_BRN, OP_JMP,
            OP_IOR, OP_IOW, OP_SHLN, OP_SHRN};

    rst_n = 1'b0; ins_in = '0; z_in = 1'b0; n_in = 1'b0;
    mem_rdy_in = 1'b1; resume_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_idle", idle_w(), all_care());
    check_val("reset_cnt", 32'(dut.cnt_r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_state", idle_w(), all_care(), 1'b1);

    // Directed cases.
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(OP_LD, 3'd5, 3'd6, 3'd0, 1'b0, 1'b0, 1, 3);
    run_instr(OP_ST, 3'd0, 3'd6, 3'd7, 1'b0, 1'b0, 0, 2);
    run_instr(OP_SHLN, 3'd2, 3'd4, 3'd5, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SHLN, 3'd2, 3'd4, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SHRN, 3'd1, 3'd7, 3'd1, 1'b0, 1'b0, 0, 0);
    run_instr(OP_SHRN, 3'd6, 3'd3, 3'd7, 1'b0, 1'b0, 0, 0);
    run_instr(OP_BRN, 3'd0, 3'd1, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(OP_BRZ, 3'd0, 3'd1, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(OP_HAL, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(OP_LDI, 3'd4, 3'd0, 3'd3, 1'b0, 1'b0, 2, 0);

    // Randomized instruction stream.
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(3) == 0) op = {3'b000, 4'($urandom_range(15))};
      else                        op = ops[$urandom_range(10)];
      run_instr(op, 3'($urandom_range(7)), 3'($urandom_range(7)),
                3'($urandom_range(7)), 1'($urandom_range(1)),
                1'($urandom_range(1)), $urandom_range(2), $urandom_range(3));
    end

`ifdef CU_ILLEGAL_TRAP_EN
    ins_in = {7'h55, 9'h0A5};
    fetch(0);
    @(negedge clk);
    e     = idle_w();
    e.ill = 1'b1;
    resume_in = 1'b1;
    for (int i = 0; i < 5; i++) step("ill_sticky", e, all_care(), 1'b1);
    resume_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check("ill_reset", idle_w(), all_care());
    @(negedge clk);
    rst_n = 1'b1;
    step("ill_rst_state", idle_w(), all_care(), 1'b1);
`else
    run_instr(7'h55, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 0, 0);
`endif

    // Reset asserted mid-loop.
    ins_in = {OP_SHLN, 3'd5, 3'd2, 3'd6};
    fetch(0);
    e    = idle_w();
    e.rw = 1'b1; e.fs = 4'b1110; e.rs = {1'b0, 3'd5, 1'b0, 3'd2, 1'b0, 3'd6};
    step("xl_ex0", e, all_care(), 1'b1);
    e.rs = {1'b0, 3'd5, 1'b0, 3'd5, 4'b0000};
    step("xl_1", e, all_care(), 1'b1);
    step("xl_2", e, all_care(), 1'b1);
    rst_n = 1'b0;
    #1;
    check("xl_reset_idle", idle_w(), all_care());
    check_val("xl_reset_cnt", 32'(dut.cnt_r), 32'd0);
    check_val("xl_reset_state", 32'(dut.state_q), 32'(ST_RST));
    @(negedge clk);
    rst_n = 1'b1;
    step("xl_rst_state", idle_w(), all_care(), 1'b1);
    run_instr(OP_SHRN, 3'd3, 3'd1, 3'd3, 1'b0, 1'b0, 0, 0);
    run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
